control_unit_packet_to_flit: RTL and testbench

Transmit-side segmenter in the memory-controller network interface, the counterpart of the flit-to-packet rebuilder.
- Accepts one packet body plus routing info through a valid/ready handshake.
- Slices the body into `PAYLOAD_W chunks, lowest bits first.
- Emits flit_t words (HEADER/BODY/TAIL, or HT for single-flit packets) toward the router under flit-level back-pressure.

---
 rtl/npu_network_defines.sv | 47 ++++
 rtl/packet_flit_slicer.sv | 57 +++++
 rtl/control_unit_packet_to_flit.sv | 133 +++++++++++++
 tb/tb_control_unit_packet_to_flit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_network_defines.sv
// ============================================================================
// Module      : npu_network_defines (package)
// Description : Shared network-interface flit and addressing types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif
`ifndef VC_ID_W
`define VC_ID_W 2
`endif

package npu_network_defines;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_t;

  typedef enum logic [0:0] {
    TO_CC = 1'b0,
    TO_DC = 1'b1
  } tile_destination_t;

  typedef logic [5:0] tile_address_t;

  typedef logic [`PAYLOAD_W-1:0] flit_body_t;

  typedef struct packed {
    flit_type_t            flit_type;
    logic [`VC_ID_W-1:0]   vc;
    tile_address_t         destination;
    tile_destination_t     core_destination;
  } flit_header_t;

  typedef struct packed {
    flit_header_t header;
    flit_body_t   payload;
  } flit_t;

endpackage

`default_nettype wire

// File: rtl/packet_flit_slicer.sv
// ============================================================================
// Module      : packet_flit_slicer
// Description : Combinational chunk select and flit typing for the segmenter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_flit_slicer
  import npu_network_defines::*;
#(
  parameter int PACKET_BODY_SIZE = 256,
  parameter int FLIT_NUMB        = (PACKET_BODY_SIZE + `PAYLOAD_W - 1) / `PAYLOAD_W,
  parameter int CNT_W            = $clog2(FLIT_NUMB + 1)
) (
  input  logic [PACKET_BODY_SIZE-1:0] body,
  input  logic [CNT_W-1:0]            count,
  output flit_body_t                  payload,
  output flit_type_t                  flit_type
);

  localparam int              c_padded_w = FLIT_NUMB * `PAYLOAD_W;
  localparam int              c_pad_w    = c_padded_w - PACKET_BODY_SIZE;
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(FLIT_NUMB - 1);

  logic [c_padded_w-1:0] w_padded;

  // Zero-extend so the last chunk's unused upper bits read as zero.
  if (c_pad_w > 0) begin : g_pad
    assign w_padded = {{c_pad_w{1'b0}}, body};
  end else begin : g_no_pad
    assign w_padded = body;
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < FLIT_NUMB; i++) begin
      if (count == CNT_W'(i)) begin
        payload = w_padded[i*`PAYLOAD_W +: `PAYLOAD_W];
      end
    end
  end

  always_comb begin
    if (FLIT_NUMB == 1) begin
      flit_type = HT;
    end else if (count == '0) begin
      flit_type = HEADER;
    end else if (count == c_last) begin
      flit_type = TAIL;
    end else begin
      flit_type = BODY;
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_unit_packet_to_flit.sv
// ============================================================================
// Module      : control_unit_packet_to_flit
// Description : Transmit segmenter: packet in, HEADER/BODY/TAIL/HT flits out.
//               NI_P2F_BACK2BACK_EN enables zero-bubble packet streaming.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit_packet_to_flit
  import npu_network_defines::*;
#(
  parameter int PACKET_BODY_SIZE = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        packet_valid,
  input  logic [PACKET_BODY_SIZE-1:0] packet_body,
  input  tile_address_t               packet_destination,
  input  tile_destination_t           packet_core_destination,
  input  logic [`VC_ID_W-1:0]         packet_vc,
  output logic                        cu_packet_ready,
  input  logic                        router_flit_ready,
  output logic                        cu_flit_valid,
  output flit_t                       cu_flit_out
);

  localparam int               c_flit_numb = (PACKET_BODY_SIZE + `PAYLOAD_W - 1) / `PAYLOAD_W;
  localparam int               c_cnt_w     = $clog2(c_flit_numb + 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_flit_numb - 1);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_cnt_w-1:0]          r_count;
  logic [c_cnt_w-1:0]          w_count_nxt;
  logic [PACKET_BODY_SIZE-1:0] r_body;
  tile_address_t               r_destination;
  tile_destination_t           r_core_destination;
  logic [`VC_ID_W-1:0]         r_vc;
  logic                        w_load;
  logic                        w_last;
  flit_body_t                  w_payload;
  flit_type_t                  w_flit_type;

  assign w_last = (r_count == c_last);
  assign w_load = packet_valid & cu_packet_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= IDLE;
      r_count            <= '0;
      r_body             <= '0;
      r_destination      <= '0;
      r_core_destination <= TO_CC;
      r_vc               <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load) begin
        r_body             <= packet_body;
        r_destination      <= packet_destination;
        r_core_destination <= packet_core_destination;
        r_vc               <= packet_vc;
      end
    end
  end

  always_comb begin
    cu_packet_ready = 1'b0;
    cu_flit_valid   = 1'b0;
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    case (r_state)
      IDLE: begin
        cu_packet_ready = enable & ~reset;
      end
      SEND: begin
        cu_flit_valid = enable;
`ifdef NI_P2F_BACK2BACK_EN
        // Overlap the next acceptance with the final flit transfer.
        cu_packet_ready = enable & router_flit_ready & w_last & ~reset;
`endif
        if (cu_flit_valid & router_flit_ready) begin
          if (w_last) begin
            w_count_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_count_nxt = r_count + c_one;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_load) begin
      w_state_nxt = SEND;
      w_count_nxt = '0;
    end
  end

  packet_flit_slicer #(
    .PACKET_BODY_SIZE (PACKET_BODY_SIZE),
    .FLIT_NUMB        (c_flit_numb),
    .CNT_W            (c_cnt_w)
  ) u_slicer (
    .body      (r_body),
    .count     (r_count),
    .payload   (w_payload),
    .flit_type (w_flit_type)
  );

  // Flit is driven only while a packet is in flight so the idle bus reads zero.
  always_comb begin
    cu_flit_out = '0;
    if (r_state == SEND) begin
      cu_flit_out.header.flit_type        = w_flit_type;
      cu_flit_out.header.vc               = r_vc;
      cu_flit_out.header.destination      = r_destination;
      cu_flit_out.header.core_destination = r_core_destination;
      cu_flit_out.payload                 = w_payload;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit_packet_to_flit.sv
// ============================================================================
// Module      : tb_control_unit_packet_to_flit
// Description : Directed bench for the packet-to-flit segmenter (256b and 40b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit_packet_to_flit;
  import npu_network_defines::*;

`ifdef NI_P2F_BACK2BACK_EN
  localparam bit c_b2b = 1'b1;
`else
  localparam bit c_b2b = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 router_flit_ready;

  logic                 packet_valid;
  logic [255:0]         packet_body;
  tile_address_t        packet_destination;
  tile_destination_t    packet_core_destination;
  logic [`VC_ID_W-1:0]  packet_vc;
  logic                 cu_packet_ready;
  logic                 cu_flit_valid;
  flit_t                cu_flit_out;

  logic                 s_packet_valid;
  logic [39:0]          s_packet_body;
  logic                 s_cu_packet_ready;
  logic                 s_cu_flit_valid;
  flit_t                s_cu_flit_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_unit_packet_to_flit #(.PACKET_BODY_SIZE(256)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .packet_valid            (packet_valid),
    .packet_body             (packet_body),
    .packet_destination      (packet_destination),
    .packet_core_destination (packet_core_destination),
    .packet_vc               (packet_vc),
    .cu_packet_ready         (cu_packet_ready),
    .router_flit_ready       (router_flit_ready),
    .cu_flit_valid           (cu_flit_valid),
    .cu_flit_out             (cu_flit_out)
  );

  control_unit_packet_to_flit #(.PACKET_BODY_SIZE(40)) dut_s (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .packet_valid            (s_packet_valid),
    .packet_body             (s_packet_body),
    .packet_destination      (6'h2A),
    .packet_core_destination (TO_CC),
    .packet_vc               (2'd3),
    .cu_packet_ready         (s_cu_packet_ready),
    .router_flit_ready       (router_flit_ready),
    .cu_flit_valid           (s_cu_flit_valid),
    .cu_flit_out             (s_cu_flit_out)
  );

  function automatic flit_t mk(input flit_type_t t, input logic [`VC_ID_W-1:0] vc,
                               input tile_address_t d, input tile_destination_t c,
                               input flit_body_t p);
    flit_t f;
    f.header.flit_type        = t;
    f.header.vc               = vc;
    f.header.destination      = d;
    f.header.core_destination = c;
    f.payload                 = p;
    return f;
  endfunction

  function automatic flit_type_t type4(input int i);
    return (i == 0) ? HEADER : (i == 3) ? TAIL : BODY;
  endfunction

  function automatic logic [255:0] body4(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; router_flit_ready = 1'b1;
    packet_valid = 1'b0; packet_body = '0;
    packet_destination = 6'h15; packet_core_destination = TO_DC; packet_vc = 2'd2;
    s_packet_valid = 1'b0; s_packet_body = 40'hAB_CDEF_0123;

    // Reset state
    step(); step();
    check("rst_ready", 128'(cu_packet_ready), 128'(0));
    check("rst_valid", 128'(cu_flit_valid), 128'(0));
    check("rst_flit",  128'(cu_flit_out), 128'(0));
    reset = 1'b0; #1;
    check("post_rst_ready", 128'(cu_packet_ready), 128'(1));

    // 1: four-flit packet, chunks 0..3
    packet_body = body4(64'd0); packet_valid = 1'b1;
    step(); packet_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 128'(cu_flit_valid), 128'(1));
      check("t1_flit", 128'(cu_flit_out), 128'(mk(type4(i), 2'd2, 6'h15, TO_DC, 64'(i))));
      check("t1_ready", 128'(cu_packet_ready), 128'(c_b2b && i == 3));
      step();
    end
    check("t1_idle_valid", 128'(cu_flit_valid), 128'(0));
    check("t1_idle_ready", 128'(cu_packet_ready), 128'(1));

    // 2: 40-bit body, single HT flit with zero padding
    s_packet_valid = 1'b1;
    step(); s_packet_valid = 1'b0; #1;
    check("t2_valid", 128'(s_cu_flit_valid), 128'(1));
    check("t2_flit", 128'(s_cu_flit_out), 128'(mk(HT, 2'd3, 6'h2A, TO_CC, 64'h0000_00AB_CDEF_0123)));
    step();
    check("t2_idle_valid", 128'(s_cu_flit_valid), 128'(0));
    check("t2_idle_ready", 128'(s_cu_packet_ready), 128'(1));

    // 3: back-pressure at flit 2 for 5 cycles
    packet_body = body4(64'hC0DE_0000_0000_0000); packet_valid = 1'b1;
    step(); packet_valid = 1'b0; #1;
    check("t3_f0", 128'(cu_flit_out), 128'(mk(HEADER, 2'd2, 6'h15, TO_DC, 64'hC0DE_0000_0000_0000)));
    step();
    check("t3_f1", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'hC0DE_0000_0000_0001)));
    step();
    router_flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_valid", 128'(cu_flit_valid), 128'(1));
      check("t3_hold_flit", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'hC0DE_0000_0000_0002)));
      step();
    end
    router_flit_ready = 1'b1; #1;
    check("t3_f2", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'hC0DE_0000_0000_0002)));
    step();
    check("t3_f3", 128'(cu_flit_out), 128'(mk(TAIL, 2'd2, 6'h15, TO_DC, 64'hC0DE_0000_0000_0003)));
    step();
    check("t3_idle_valid", 128'(cu_flit_valid), 128'(0));

    // 4: enable low mid-packet; a competing packet_valid in SEND is ignored
    packet_body = body4(64'hE000); packet_valid = 1'b1;
    step();
    packet_body = body4(64'hF000); #1;
    check("t4_f0", 128'(cu_flit_out), 128'(mk(HEADER, 2'd2, 6'h15, TO_DC, 64'hE000)));
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_en_valid", 128'(cu_flit_valid), 128'(0));
      check("t4_en_ready", 128'(cu_packet_ready), 128'(0));
      step();
    end
    enable = 1'b1; #1;
    check("t4_resume_valid", 128'(cu_flit_valid), 128'(1));
    check("t4_f1", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'hE001)));
    step();
    check("t4_f2", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'hE002)));
    step();
    packet_valid = 1'b0; #1;
    check("t4_f3", 128'(cu_flit_out), 128'(mk(TAIL, 2'd2, 6'h15, TO_DC, 64'hE003)));
    step();
    check("t4_idle_valid", 128'(cu_flit_valid), 128'(0));

    // 5: reset at flit 1, then a fresh packet starts at HEADER/chunk 0
    packet_body = body4(64'h5000); packet_valid = 1'b1;
    step(); packet_valid = 1'b0;
    step();
    check("t5_f1", 128'(cu_flit_out), 128'(mk(BODY, 2'd2, 6'h15, TO_DC, 64'h5001)));
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    check("t5_rst_valid", 128'(cu_flit_valid), 128'(0));
    check("t5_rst_ready", 128'(cu_packet_ready), 128'(1));
    packet_body = body4(64'h6000); packet_valid = 1'b1;
    step(); packet_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_flit", 128'(cu_flit_out), 128'(mk(type4(i), 2'd2, 6'h15, TO_DC, 64'h6000 + 64'(i))));
      step();
    end
    check("t5_idle_valid", 128'(cu_flit_valid), 128'(0));

    // 6: two queued packets; gap depends on back-to-back build
    packet_body = body4(64'h7000); packet_valid = 1'b1;
    step();
    packet_body = body4(64'h8000);
    packet_destination = 6'h01; packet_core_destination = TO_CC; packet_vc = 2'd1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_a", 128'(cu_flit_out), 128'(mk(type4(i), 2'd2, 6'h15, TO_DC, 64'h7000 + 64'(i))));
      step();
    end
    if (!c_b2b) begin
      check("t6_gap_valid", 128'(cu_flit_valid), 128'(0));
      step();
    end
    packet_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_b_valid", 128'(cu_flit_valid), 128'(1));
      check("t6_b", 128'(cu_flit_out), 128'(mk(type4(i), 2'd1, 6'h01, TO_CC, 64'h8000 + 64'(i))));
      step();
    end
    check("t6_idle_valid", 128'(cu_flit_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
